// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
// Valid/ready: a beat transfers on the rising edge where valid && ready; the sender
// holds its payload stable while valid is high, and ready never depends on valid.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             A_gt_B;
  logic             A_eq_B;
  logic             A_lt_B;
  logic [CW-1:0]    cycles;

  modport master (
    output in_valid, A, B, is_signed, out_ready,
    input  in_ready, out_valid, A_gt_B, A_eq_B, A_lt_B, cycles
  );

  modport slave (
    input  in_valid, A, B, is_signed, out_ready,
    output in_ready, out_valid, A_gt_B, A_eq_B, A_lt_B, cycles
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK bits per cycle from the MSB chunk
// down and stops at the first differing chunk; signed mode flips the top chunk MSB.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CW    = $clog2(WIDTH / CHUNK + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seq_magnitude_comparator_if.slave bus,
  output logic [1:0]               dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic             out_valid_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic [CW-1:0]    cycles_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CW-1:0]    used;

  // Inverting the sign bit of the top chunk turns a signed compare into an unsigned one.
  always_comb begin
    ca = a_q[int'(idx)*CHUNK +: CHUNK];
    cb = b_q[int'(idx)*CHUNK +: CHUNK];
    if (sgn_q && (int'(idx) == NCHUNK - 1)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    used = CW'(NCHUNK - int'(idx));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      cycles_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            sgn_q <= bus.is_signed;
            idx   <= IW'(NCHUNK - 1);
            state <= CMP;
          end
        end
        CMP: begin
          if (ca != cb) begin
            gt_q        <= (ca > cb);
            lt_q        <= (ca < cb);
            cycles_q    <= used;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            eq_q        <= 1'b1;
            cycles_q    <= used;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.A_gt_B    = gt_q;
  assign bus.A_eq_B    = eq_q;
  assign bus.A_lt_B    = lt_q;
  assign bus.cycles    = cycles_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: a 4-chunk build (CHUNK=8) and a 1-chunk build (CHUNK=32).
module tb_seq_magnitude_comparator;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(32), .CW(3)) bus0 ();
  seq_magnitude_comparator_if #(.WIDTH(32), .CW(1)) bus1 ();
  logic [1:0] dbg0;
  logic [1:0] dbg1;

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0)
  );
  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  // Expected {gt, eq, lt, cycles[3:0]} per accepted transaction.
  logic [6:0] exp_q[$];

  // Reference: plain signed/unsigned relational operators; cycles from the highest
  // differing bit position (a^b) divided into chunks.
  function automatic logic [6:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic s, input int nch);
    int chunk;
    int p;
    int cyc;
    logic gt;
    logic eq;
    logic lt;
    logic [31:0] x;
    chunk = 32 / nch;
    if (s) begin
      gt = ($signed(a) > $signed(b));
      lt = ($signed(a) < $signed(b));
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
    eq = (a == b);
    x = a ^ b;
    p = -1;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    cyc = (p < 0) ? nch : nch - p / chunk;
    return {gt, eq, lt, 4'(cyc)};
  endfunction

  // {in_ready, out_valid, gt, eq, lt, cycles[3:0]}
  function automatic logic [8:0] obs(input bit sel);
    if (sel) return {bus1.in_ready, bus1.out_valid, bus1.A_gt_B, bus1.A_eq_B, bus1.A_lt_B, 4'(bus1.cycles)};
    return {bus0.in_ready, bus0.out_valid, bus0.A_gt_B, bus0.A_eq_B, bus0.A_lt_B, 4'(bus0.cycles)};
  endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) bus1.in_valid = v;
    else bus0.in_valid = v;
  endtask

  task automatic drive_ops(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus0.A = a; bus1.A = a;
    bus0.B = b; bus1.B = b;
    bus0.is_signed = s; bus1.is_signed = s;
  endtask

  task automatic set_out_ready(input logic v);
    bus0.out_ready = v;
    bus1.out_ready = v;
  endtask

  // Returns at the falling edge right after the accepting edge, with in_valid dropped.
  task automatic send(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [8:0] o;
    int waitc;
    @(negedge clk);
    drive_ops(a, b, s);
    set_valid(sel, 1'b1);
    waitc = 0;
    o = obs(sel);
    while (!o[8] && waitc < 50) begin
      @(negedge clk);
      waitc++;
      o = obs(sel);
    end
    n_tests++;
    if (o[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout got in_ready=%b need 1", o[8]);
    end
    @(posedge clk);
    @(negedge clk);
    set_valid(sel, 1'b0);
    exp_q.push_back(model(a, b, s, sel ? 1 : 4));
  endtask

  task automatic check_result(input bit sel, input string name);
    logic [8:0] o;
    logic [6:0] e;
    int lat;
    lat = 0;
    o = obs(sel);
    while (!o[7] && lat < 64) begin
      n_tests++;
      if (o[6:4] !== 3'b000) begin
        n_fail++;
        $display("FAIL %s flags_while_busy got=%b need=000", name, o[6:4]);
      end
      @(negedge clk);
      lat++;
      o = obs(sel);
    end
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard_empty got size 0 need >0", name);
      return;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (o[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid_timeout got=%b need=1", name, o[7]);
    end
    n_tests++;
    if (o[6:0] !== e) begin
      n_fail++;
      $display("FAIL %s result got gt/eq/lt=%b cyc=%0d need gt/eq/lt=%b cyc=%0d",
               name, o[6:4], o[3:0], e[6:4], e[3:0]);
    end
    n_tests++;
    if (lat !== int'(e[3:0])) begin
      n_fail++;
      $display("FAIL %s latency got=%0d need=%0d", name, lat, e[3:0]);
    end
    if (bus0.out_ready) begin
      @(negedge clk);
      o = obs(sel);
      n_tests++;
      if (o[8:7] !== 2'b10) begin
        n_fail++;
        $display("FAIL %s consume got in_ready/out_valid=%b need=10", name, o[8:7]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_out_ready(1'b1);
    drive_ops(32'h1234_5678, 32'h1234_5678, 1'b0);
    bus0.in_valid = 1'b1;
    bus1.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs(0) !== 9'b1_0_000_0000 || dbg0 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dut0 got=%b state=%0d need=100000000 state=0", obs(0), dbg0);
    end
    n_tests++;
    if (obs(1) !== 9'b1_0_000_0000 || dbg1 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 got=%b state=%0d need=100000000 state=0", obs(1), dbg1);
    end
    // Release with in_valid still high: dut0 captures on the very next edge.
    bus1.in_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.push_back(model(32'h1234_5678, 32'h1234_5678, 1'b0, 4));
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check_result(0, "equal_after_reset");
  endtask

  task automatic test_directed();
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    logic        ts[4];
    ta = '{32'h8000_0000, 32'h8000_0000, 32'h0000_01FF, 32'hFFFF_FFFE};
    tb = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0200, 32'hFFFF_FFFF};
    ts = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(0, ta[i], tb[i], ts[i]);
      check_result(0, $sformatf("directed%0d", i));
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] o0;
    logic [8:0] o;
    set_out_ready(1'b0);
    send(0, 32'd5, 32'd3, 1'b0);
    check_result(0, "bp_hold");
    o0 = obs(0);
    drive_ops(32'd7, 32'd9, 1'b0);
    bus0.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = obs(0);
      n_tests++;
      if (o !== o0 || o[8] !== 1'b0 || dbg0 !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_stable cyc%0d got=%b state=%0d need=%b state=2", i, o, dbg0, o0);
      end
    end
    set_out_ready(1'b1);
    @(negedge clk);
    o = obs(0);
    n_tests++;
    if (o[8:7] !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release got in_ready/out_valid=%b need=10", o[8:7]);
    end
    exp_q.push_back(model(32'd7, 32'd9, 1'b0, 4));
    @(posedge clk);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check_result(0, "bp_next");
  endtask

  task automatic test_reset_mid();
    send(0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs(0) !== 9'b1_0_000_0000 || dbg0 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b state=%0d need=100000000 state=0", obs(0), dbg0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 32'd1, 32'd2, 1'b0);
    check_result(0, "after_reset_mid");
  endtask

  task automatic rand_ops(output logic [31:0] a, output logic [31:0] b, output logic s);
    a = $urandom;
    case ($urandom_range(0, 3))
      0: b = $urandom;
      1: b = a;
      2: b = a ^ (32'h1 << $urandom_range(0, 31));
      default: b = {a[31:16], 16'($urandom_range(0, 65535))};
    endcase
    s = 1'($urandom_range(0, 1));
  endtask

  task automatic test_back_to_back(input bit sel, input int n);
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    for (int i = 0; i < n; i++) begin
      rand_ops(a, b, s);
      send(sel, a, b, s);
      check_result(sel, $sformatf("rand_dut%0d_%0d", sel, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    drive_ops('0, '0, 1'b0);
    set_out_ready(1'b1);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back(0, 40);
    test_back_to_back(1, 20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
